// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial wrapper that walks an external 8:1 mux across a held word.
// Optional even-parity trailer beat when MUX_SCAN_SERIALIZER_PARITY_EN is defined.
`default_nettype none

module mux_scan_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mux_i,
  output logic [2:0] sel,
  input  logic       mux_y,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 8'h00;
      sel_q   <= 3'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_bit   = mux_y;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = data_in;
          cnt_d   = 3'd0;
          sel_d   = SEL_START;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
`ifndef MUX_SCAN_SERIALIZER_PARITY_EN
        out_last  = (cnt_q == 3'd7);
`endif
        if (out_ready) begin
          if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
            sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
          end else begin
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
      PAR: begin
        // sel stays parked on the last data bit while the parity beat goes out
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_bit   = ^hold_q;
        if (out_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign mux_i = hold_q;
  assign sel   = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: LSB-first and MSB-first instances share stimulus.
`default_nettype none

module tb_mux_scan_serializer;

`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct packed {
    logic       b;
    logic [2:0] s;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready  [2];
  logic [7:0] mux_i     [2];
  logic [2:0] sel       [2];
  logic       mux_y     [2];
  logic       out_bit   [2];
  logic       out_valid [2];
  logic       out_last  [2];

  logic [15:0] cap   [2];
  int          beats [2];
  int          lasts [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    // Behavioural stand-in for the external 8:1 mux.
    assign mux_y[g] = mux_i[g][sel[g]];

    mux_scan_serializer #(.MSB_FIRST(g == 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .mux_i     (mux_i[g]),
      .sel       (sel[g]),
      .mux_y     (mux_y[g]),
      .out_bit   (out_bit[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_last  (out_last[g])
    );

    // Model: a word becomes a queue of expected beats; empty queue means idle.
    beat_t      q[$];
    logic [7:0] m_hold;
    logic [2:0] m_isel;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        m_hold = 8'h00;
        m_isel = 3'd0;
      end else if (q.size() > 0) begin
        if (out_ready) begin
          m_isel = q[0].s;
          void'(q.pop_front());
        end
      end else if (in_valid) begin
        m_hold = data_in;
        for (int k = 0; k < NB; k++) begin
          beat_t bt;
          int    pos;
          if (k < 8) begin
            pos  = (g == 1) ? 7 - k : k;
            bt.b = data_in[pos];
            bt.s = 3'(pos);
            bt.l = (k == 7) && (NB == 8);
          end else begin
            bt.b = ^data_in;
            bt.s = (g == 1) ? 3'd0 : 3'd7;
            bt.l = 1'b1;
          end
          q.push_back(bt);
        end
      end
    end

    always @(negedge clk) begin
      logic busy;
      busy = (q.size() > 0);
      chk($sformatf("out_valid[%0d]", g), 32'(out_valid[g]), 32'(busy));
      chk($sformatf("in_ready[%0d]", g), 32'(in_ready[g]), 32'(!busy));
      chk($sformatf("mux_i[%0d]", g), 32'(mux_i[g]), 32'(m_hold));
      chk($sformatf("sel[%0d]", g), 32'(sel[g]), 32'(busy ? q[0].s : m_isel));
      chk($sformatf("out_last[%0d]", g), 32'(out_last[g]), 32'(busy ? q[0].l : 1'b0));
      if (busy) chk($sformatf("out_bit[%0d]", g), 32'(out_bit[g]), 32'(q[0].b));
      if (rst_n && out_ready && out_valid[g]) begin
        cap[g] = {cap[g][14:0], out_bit[g]};
        beats[g]++;
        if (out_last[g]) lasts[g]++;
      end
    end
  end

  task automatic clear_cap();
    for (int i = 0; i < 2; i++) begin
      cap[i]   = 16'h0;
      beats[i] = 0;
      lasts[i] = 0;
    end
  endtask

  task automatic load(input logic [7:0] w);
    bit done = 0;
    data_in  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      if (in_ready[0]) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_beats(input int n);
    bit done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk);
      #1;
      if (beats[0] >= n) done = 1;
    end
    if (!done) chk("beat_timeout", 32'(beats[0]), 32'(n));
  endtask

  task automatic check_word(input string name, input logic [7:0] e0, input logic [7:0] e1);
    chk({name, "_lsb_bits"}, 32'(cap[0] >> (NB - 8)), 32'(e0));
    chk({name, "_msb_bits"}, 32'(cap[1] >> (NB - 8)), 32'(e1));
    chk({name, "_beats"}, 32'(beats[0]), 32'(NB));
    chk({name, "_lasts"}, 32'(lasts[0]), 32'd1);
  endtask

  task automatic reset_values(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_in_ready"}, 32'(in_ready[i]), 32'd1);
      chk({name, "_out_valid"}, 32'(out_valid[i]), 32'd0);
      chk({name, "_out_last"}, 32'(out_last[i]), 32'd0);
      chk({name, "_sel"}, 32'(sel[i]), 32'd0);
      chk({name, "_mux_i"}, 32'(mux_i[i]), 32'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = 8'h00;
    clear_cap();
    #2 rst_n = 1'b0;
    #1 reset_values("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Bits are captured first-bit-into-MSB, so the LSB-first stream of A5 reads A5.
    clear_cap(); load(8'hA5); wait_beats(NB);
    check_word("a5", 8'hA5, 8'hA5);
    chk("a5_in_ready_after", 32'(in_ready[0]), 32'd1);

    clear_cap(); load(8'h81); wait_beats(NB);
    check_word("x81", 8'h81, 8'h81);

    clear_cap(); load(8'h07); wait_beats(NB);
    check_word("x07", 8'hE0, 8'h07);
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
    chk("x07_parity", 32'(cap[0][0]), 32'd1);
`endif

    clear_cap(); load(8'h03); wait_beats(NB);
    check_word("x03", 8'hC0, 8'h03);
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
    chk("x03_parity", 32'(cap[0][0]), 32'd0);
`endif

    // Backpressure on the third bit.
    clear_cap(); load(8'h3C); wait_beats(2);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_sel_lsb", 32'(sel[0]), 32'd2);
      chk("stall_sel_msb", 32'(sel[1]), 32'd5);
      chk("stall_bit", 32'(out_bit[0]), 32'd1);
      chk("stall_valid", 32'(out_valid[0]), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_beats(NB);
    check_word("x3c", 8'h3C, 8'h3C);

    // Asynchronous reset in the middle of a word.
    clear_cap(); load(8'hFF); wait_beats(4);
    #2 rst_n = 1'b0;
    #1 reset_values("midrst");
    chk("midrst_lasts", 32'(lasts[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_cap(); load(8'h0F); wait_beats(NB);
    check_word("x0f", 8'hF0, 8'h0F);

    // New word offered during the final beat waits for the following idle cycle.
    clear_cap(); load(8'h5A); wait_beats(NB - 1);
    data_in = 8'hC3; in_valid = 1'b1;
    @(negedge clk);
    chk("overlap_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("overlap_idle_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overlap_loaded", 32'(mux_i[0]), 32'hC3);
    clear_cap(); wait_beats(NB);
    check_word("xc3", 8'hC3, 8'hC3);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
